lcd_job_arbiter: RTL

Draw-job scheduler in front of the LCD printer's command FIFO. Up to four sprite/background requesters (map, tanks, bullets, HUD) and one LCD-init request share the single printer. The block arbitrates round-robin among draw requests, validates each job against the panel size, and serialises it into the printer's 3-word command format. It also tracks jobs in flight, throttling on a configurable limit.

---
 rtl/lcd_job_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/lcd_job_arbiter.sv
// Draw-job scheduler: round-robin arbitration, panel-bounds validation, 3-word command serialisation.
// Latency: grant is combinational in IDLE; word0 written the cycle after grant, one word per cycle after that.
// Backpressure: cmd_wfull stalls the current word (state and data held); grants are throttled at MAX_OUT jobs in flight.
//
// Ports:
//   i_clk, i_rst         clock; synchronous active-high reset
//   i_req[3:0]           per-requester level request, fields stable until grant
//   i_req_x/y/w/h        4 x 9-bit packed origin/size, requester i at [9i+8:9i]
//   i_req_addr           4 x 32-bit packed image base address (must be word aligned)
//   o_grant, o_reject    one-hot grant pulse; reject flags a grant that failed validation
//   i_init_req           LCD init request (level); o_init_ack marks the init word write
//   o_cmd_wdata/winc     command FIFO write port; i_cmd_wfull is the FIFO full flag
//   i_job_done           printer end-of-image pulse
//   o_outstanding        jobs written but not completed
//   o_busy               FSM active or jobs in flight
//   o_done_err           sticky: job_done seen with nothing outstanding

module lcd_job_arbiter #(
    parameter int LCD_W   = 240,
    parameter int LCD_H   = 320,
    parameter int MAX_OUT = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [3:0]   i_req,
    input  logic [35:0]  i_req_x,
    input  logic [35:0]  i_req_y,
    input  logic [35:0]  i_req_w,
    input  logic [35:0]  i_req_h,
    input  logic [127:0] i_req_addr,
    output logic [3:0]   o_grant,
    output logic         o_reject,
    input  logic         i_init_req,
    output logic         o_init_ack,
    output logic [31:0]  o_cmd_wdata,
    output logic         o_cmd_winc,
    input  logic         i_cmd_wfull,
    input  logic         i_job_done,
    output logic [3:0]   o_outstanding,
    output logic         o_busy,
    output logic         o_done_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_W,
        S_W0,
        S_W1,
        S_W2
    } state_t;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [8:0]  w;
        logic [8:0]  h;
        logic [31:0] addr;
    } job_t;

    localparam logic [9:0]  W_LIM   = 10'(LCD_W);
    localparam logic [9:0]  H_LIM   = 10'(LCD_H);
    localparam logic [3:0]  OUT_LIM = 4'(MAX_OUT);
    localparam logic [31:0] INIT_WORD = 32'h8000_0000;

    function automatic logic [31:0] f_word0(input job_t j);
        return {1'b0, 6'b0, j.x, 7'b0, j.y};
    endfunction

    function automatic logic [31:0] f_word1(input job_t j);
        return {7'b0, j.w, 7'b0, j.h};
    endfunction

    state_t      r_state;
    logic [1:0]  r_rr_ptr;
    job_t        r_job;
    logic [31:0] r_cmd_wdata;
    logic [3:0]  r_outstanding;
    logic        r_done_err;

    logic        w_found;
    logic [1:0]  w_sel;
    logic [1:0]  w_idx;
    job_t        w_job;
    logic [9:0]  w_xsum;
    logic [9:0]  w_ysum;
    logic        w_bad;
    logic        w_idle;
    logic        w_init_go;
    logic        w_grant_go;
    logic        w_write_st;
    logic        w_fire;
    logic        w_inc;
    logic        w_dec;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping 3->0.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_rr_ptr;
        w_idx   = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_rr_ptr + 2'(k);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Fields of the selected requester, as seen on the grant edge.
    always_comb begin
        w_job.x    = i_req_x[9*w_sel +: 9];
        w_job.y    = i_req_y[9*w_sel +: 9];
        w_job.w    = i_req_w[9*w_sel +: 9];
        w_job.h    = i_req_h[9*w_sel +: 9];
        w_job.addr = i_req_addr[32*w_sel +: 32];
    end

    // 10-bit sums so x+w cannot wrap for any 9-bit operands.
    assign w_xsum = {1'b0, w_job.x} + {1'b0, w_job.w};
    assign w_ysum = {1'b0, w_job.y} + {1'b0, w_job.h};
    assign w_bad  = (w_job.w == 9'd0) || (w_job.h == 9'd0) ||
                    (w_xsum > W_LIM)  || (w_ysum > H_LIM)  ||
                    (w_job.addr[1:0] != 2'b00);

    // Nothing is granted or written while reset is asserted.
    assign w_idle     = (r_state == S_IDLE) && !i_rst;
    assign w_init_go  = w_idle && i_init_req;
    assign w_grant_go = w_idle && !i_init_req && w_found && (r_outstanding < OUT_LIM);

    assign w_write_st = (r_state == S_INIT_W) || (r_state == S_W0) ||
                        (r_state == S_W1)     || (r_state == S_W2);
    assign w_fire     = w_write_st && !i_cmd_wfull && !i_rst;

    assign w_inc = (r_state == S_W2) && w_fire;
    assign w_dec = i_job_done && (r_outstanding != 4'd0);

    assign o_grant       = w_grant_go ? (4'b0001 << w_sel) : 4'b0000;
    assign o_reject      = w_grant_go && w_bad;
    assign o_cmd_winc    = w_fire;
    assign o_init_ack    = w_fire && (r_state == S_INIT_W);
    assign o_cmd_wdata   = r_cmd_wdata;
    assign o_outstanding = r_outstanding;
    assign o_busy        = (r_state != S_IDLE) || (r_outstanding != 4'd0);
    assign o_done_err    = r_done_err;

    // r_cmd_wdata is loaded with the word for the state being entered, so it
    // is already valid on the first cycle of each write state and reads 0 in IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= 2'd0;
            r_job         <= '0;
            r_cmd_wdata   <= 32'd0;
            r_outstanding <= 4'd0;
            r_done_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_init_go) begin
                        r_state     <= S_INIT_W;
                        r_cmd_wdata <= INIT_WORD;
                    end else if (w_grant_go) begin
                        r_job    <= w_job;
                        r_rr_ptr <= w_sel + 2'd1;
                        // A rejected job consumes its grant but stays in IDLE.
                        if (!w_bad) begin
                            r_state     <= S_W0;
                            r_cmd_wdata <= f_word0(w_job);
                        end
                    end
                end
                S_INIT_W: begin
                    if (!i_cmd_wfull) begin
                        r_state     <= S_IDLE;
                        r_cmd_wdata <= 32'd0;
                    end
                end
                S_W0: begin
                    if (!i_cmd_wfull) begin
                        r_state     <= S_W1;
                        r_cmd_wdata <= f_word1(r_job);
                    end
                end
                S_W1: begin
                    if (!i_cmd_wfull) begin
                        r_state     <= S_W2;
                        r_cmd_wdata <= r_job.addr;
                    end
                end
                S_W2: begin
                    if (!i_cmd_wfull) begin
                        r_state     <= S_IDLE;
                        r_cmd_wdata <= 32'd0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_wdata <= 32'd0;
                end
            endcase

            // Completion and a new W2 write in the same cycle cancel out.
            case ({w_inc, w_dec})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase

            if (i_job_done && (r_outstanding == 4'd0)) begin
                r_done_err <= 1'b1;
            end
        end
    end

endmodule
